// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD host sequencer.
//   - sequencer state encoding
//   - default WIDTH / TIMEOUT / RST_CYCLES
//   - width helper for the shared FLUSH/WAIT counter
package gcd_pkg;

  localparam int unsigned GCD_WIDTH      = 16;
  localparam int unsigned GCD_TIMEOUT    = 1023;
  localparam int unsigned GCD_RST_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_WAIT,
    ST_HOLD
  } state_t;

  // One counter serves both the flush length and the wait budget, so it
  // must be wide enough for whichever terminal value is larger.
  function automatic int unsigned cnt_width(input int unsigned timeout,
                                            input int unsigned rst_cycles);
    int unsigned m;
    m = (timeout > rst_cycles) ? timeout : rst_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gcd_seq_counter.sv
// gcd_seq_counter: clearable, saturating up-counter with terminal-count compare.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clr        : synchronous clear to zero (priority over i_en)
//   i_en         : count enable; holds at all-ones instead of wrapping
//   i_limit      : terminal value
//   o_tc         : current count equals i_limit
module gcd_seq_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [CW-1:0] i_limit,
  output logic          o_tc
);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == i_limit);

endmodule

// File: rtl/gcd_host_sequencer.sv
// gcd_host_sequencer: feeds operand pairs to the GCD engine using its
// A-then-B two-cycle load protocol, waits for sticky done (bounded by TIMEOUT),
// returns the result on a valid/ready stream, then pulses the engine reset.
// Pairs with a zero operand bypass the engine (it would never terminate).
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/b  : operand pair stream
//   out_valid/out_ready       : result stream
//   out_gcd, out_timeout      : result, and abandoned-run flag (out_gcd=0)
//   eng_rst/eng_start/eng_data: engine control and data bus
//   eng_done, eng_result      : engine status and A-register value
//   busy                      : high whenever not IDLE
// All outputs are registered; each is loaded from the value its next state needs.
module gcd_host_sequencer
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH      = GCD_WIDTH,
  parameter int unsigned TIMEOUT    = GCD_TIMEOUT,
  parameter int unsigned RST_CYCLES = GCD_RST_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_timeout,
  output logic             eng_rst,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_data,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_result,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(TIMEOUT, RST_CYCLES);

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_b, w_b_nx;
  logic [WIDTH-1:0] r_out_gcd, w_gcd_nx;
  logic             r_out_timeout, w_to_nx;
  logic [WIDTH-1:0] r_eng_data, w_data_nx;
  logic             r_in_ready, r_out_valid, r_eng_rst, r_eng_start, r_busy;

  logic             w_cnt_clr, w_cnt_en, w_tc;
  logic [CW-1:0]    w_limit;

  // Terminal value depends on which phase currently owns the counter.
  assign w_limit = (r_state == ST_FLUSH) ? CW'(RST_CYCLES - 1) : CW'(TIMEOUT - 1);

  gcd_seq_counter #(
    .CW (CW)
  ) u_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_state_nx = r_state;
    w_b_nx     = r_b;
    w_gcd_nx   = r_out_gcd;
    w_to_nx    = r_out_timeout;
    w_cnt_clr  = 1'b1;
    w_cnt_en   = 1'b0;
    w_data_nx  = '0;

    case (r_state)
      ST_FLUSH: begin
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b1;
        if (w_tc) w_state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_b_nx = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            w_gcd_nx   = in_a | in_b;
            w_to_nx    = 1'b0;
            w_state_nx = ST_HOLD;
          end else begin
            w_state_nx = ST_LOAD_A;
          end
        end
      end
      ST_LOAD_A: w_state_nx = ST_LOAD_B;
      // Counter is held clear here so WAIT starts counting from zero.
      ST_LOAD_B: w_state_nx = ST_WAIT;
      ST_WAIT: begin
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b1;
        if (eng_done) begin
          w_gcd_nx   = eng_result;
          w_to_nx    = 1'b0;
          w_state_nx = ST_HOLD;
        end else if (w_tc) begin
          w_gcd_nx   = '0;
          w_to_nx    = 1'b1;
          w_state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_gcd_nx   = '0;
          w_to_nx    = 1'b0;
          w_state_nx = ST_FLUSH;
        end
      end
      default: w_state_nx = ST_FLUSH;
    endcase

    // Bus content follows the state being entered: A during LOAD_A,
    // B from LOAD_B through WAIT, idle-low otherwise.
    case (w_state_nx)
      ST_LOAD_A:         w_data_nx = in_a;
      ST_LOAD_B, ST_WAIT: w_data_nx = r_b;
      default:           w_data_nx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_FLUSH;
      r_b           <= '0;
      r_out_gcd     <= '0;
      r_out_timeout <= 1'b0;
      r_eng_data    <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_eng_rst     <= 1'b1;
      r_eng_start   <= 1'b0;
      r_busy        <= 1'b1;
    end else begin
      r_state       <= w_state_nx;
      r_b           <= w_b_nx;
      r_out_gcd     <= w_gcd_nx;
      r_out_timeout <= w_to_nx;
      r_eng_data    <= w_data_nx;
      r_in_ready    <= (w_state_nx == ST_IDLE);
      r_out_valid   <= (w_state_nx == ST_HOLD);
      r_eng_rst     <= (w_state_nx == ST_FLUSH);
      r_eng_start   <= (w_state_nx == ST_LOAD_A);
      r_busy        <= (w_state_nx != ST_IDLE);
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_gcd     = r_out_gcd;
  assign out_timeout = r_out_timeout;
  assign eng_rst     = r_eng_rst;
  assign eng_start   = r_eng_start;
  assign eng_data    = r_eng_data;
  assign busy        = r_busy;

endmodule
